// File: rtl/bp_stream_pump_in.sv
// bp_stream_pump_in
//   Converts incoming bedrock memory messages (one header plus beats of
//   stream_data_width_p data) into per-beat FSM transactions, each carrying
//   its own address and beat index.
//   - Single-beat messages pass straight through.
//   - Data messages forward each bus beat 1:1 with no added latency.
//   - Data-less multi-beat messages (reads) are expanded into num_stream
//     FSM beats from one bus message.
//
// Ports
//   clk_i, reset_n_i     clock; asynchronous active-low reset
//   mem_header_i         incoming bedrock header (held while mem_v_i is high)
//   mem_data_i           beat data
//   mem_v_i              beat valid
//   mem_yumi_o           bus beat consumed
//   fsm_base_header_o    message header (registered once streaming)
//   fsm_addr_o           per-beat address
//   fsm_data_o           beat data (combinational pass-through)
//   fsm_v_o              FSM beat valid
//   fsm_yumi_i           FSM beat consumed
//   fsm_new_o            first beat of a message
//   fsm_last_o           last beat of a message
//   cnt_o                beat index within the block
//   done_o               message complete this cycle
//   error_o              sticky protocol error
//
// Configuration
//   BP_STREAM_PUMP_IN_PROTOCOL_CHECK_EN: when defined, header changes in the
//   middle of a data stream set error_o. When undefined, error_o is tied to 0.

package bp_stream_pump_in_pkg;

  typedef enum logic [0:0] {
    e_bp_default_cfg = 1'b0
  } bp_params_e;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3
  } bp_bedrock_mem_type_e;

  // Message size in bytes is 1 << size.
  typedef enum logic [2:0] {
    e_bedrock_msg_size_1   = 3'd0,
    e_bedrock_msg_size_2   = 3'd1,
    e_bedrock_msg_size_4   = 3'd2,
    e_bedrock_msg_size_8   = 3'd3,
    e_bedrock_msg_size_16  = 3'd4,
    e_bedrock_msg_size_32  = 3'd5,
    e_bedrock_msg_size_64  = 3'd6,
    e_bedrock_msg_size_128 = 3'd7
  } bp_bedrock_msg_size_e;

  function automatic int paddr_width(bp_params_e cfg);
    case (cfg)
      default: return 40;
    endcase
  endfunction

  function automatic int lce_id_width(bp_params_e cfg);
    case (cfg)
      default: return 4;
    endcase
  endfunction

  function automatic int lce_assoc(bp_params_e cfg);
    case (cfg)
      default: return 8;
    endcase
  endfunction

  function automatic int dword_width(bp_params_e cfg);
    case (cfg)
      default: return 64;
    endcase
  endfunction

  function automatic int cce_block_width(bp_params_e cfg);
    case (cfg)
      default: return 512;
    endcase
  endfunction

  // Header layout (MSB..LSB): lce_id, way, addr, size, msg_type.
  function automatic int mem_header_width(bp_params_e cfg);
    return lce_id_width(cfg) + $clog2(lce_assoc(cfg)) + paddr_width(cfg)
         + $bits(bp_bedrock_msg_size_e) + $bits(bp_bedrock_mem_type_e);
  endfunction

endpackage

module bp_stream_pump_in
  import bp_stream_pump_in_pkg::*;
#(
  parameter bp_params_e  bp_params_p         = e_bp_default_cfg,
  parameter int          stream_data_width_p = dword_width(bp_params_p),
  parameter int          block_width_p       = cce_block_width(bp_params_p),
  parameter logic [15:0] payload_mask_p      = '0,
  localparam int paddr_width_lp  = paddr_width(bp_params_p),
  localparam int hdr_width_lp    = mem_header_width(bp_params_p),
  localparam int stream_words_lp = block_width_p / stream_data_width_p,
  localparam int cnt_width_lp    = $clog2(stream_words_lp)
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,

  input  logic [hdr_width_lp-1:0]        mem_header_i,
  input  logic [stream_data_width_p-1:0] mem_data_i,
  input  logic                           mem_v_i,
  output logic                           mem_yumi_o,

  output logic [hdr_width_lp-1:0]        fsm_base_header_o,
  output logic [paddr_width_lp-1:0]      fsm_addr_o,
  output logic [stream_data_width_p-1:0] fsm_data_o,
  output logic                           fsm_v_o,
  input  logic                           fsm_yumi_i,

  output logic                           fsm_new_o,
  output logic                           fsm_last_o,
  output logic [cnt_width_lp-1:0]        cnt_o,
  output logic                           done_o,
  output logic                           error_o
);

  localparam int unsigned beat_bytes_lp = stream_data_width_p / 8;
  localparam int byte_off_lp = $clog2(beat_bytes_lp);
  localparam int blk_off_lp  = byte_off_lp + cnt_width_lp;
  localparam logic [cnt_width_lp:0] one_beat_lp = 1;

  typedef struct packed {
    logic [lce_id_width(bp_params_p)-1:0]        lce_id;
    logic [$clog2(lce_assoc(bp_params_p))-1:0]   way;
    logic [paddr_width_lp-1:0]                   addr;
    bp_bedrock_msg_size_e                        size;
    bp_bedrock_mem_type_e                        msg_type;
  } mem_header_s;

  typedef enum logic [1:0] {
    e_ready,
    e_stream,
    e_expand
  } state_e;

  // Beats in a message, clamped to [1, stream_words]. One bit wider than the
  // counter so a full block does not alias to zero.
  function automatic logic [cnt_width_lp:0] calc_num_stream(bp_bedrock_msg_size_e size);
    int unsigned beats;
    beats = (32'd1 << size) / beat_bytes_lp;
    if (beats == 0) beats = 1;
    if (beats > stream_words_lp) beats = stream_words_lp;
    return beats[cnt_width_lp:0];
  endfunction

  state_e                  state_q, state_d;
  mem_header_s             header_q, header_d;
  logic [cnt_width_lp-1:0] cnt_q, cnt_d;

  mem_header_s             mem_header_li;
  mem_header_s             hdr_cur;
  logic [cnt_width_lp:0]   num_stream;
  logic [cnt_width_lp-1:0] first_cnt, last_cnt;
  logic                    single_beat, has_data, accept;

  assign mem_header_li = mem_header_s'(mem_header_i);

  // In e_ready the live bus header describes the message; afterwards the
  // registered copy does, so a changing bus header cannot disturb a stream.
  assign hdr_cur     = (state_q == e_ready) ? mem_header_li : header_q;
  assign num_stream  = calc_num_stream(hdr_cur.size);
  assign single_beat = (num_stream == one_beat_lp);
  assign has_data    = payload_mask_p[hdr_cur.msg_type];
  assign first_cnt   = hdr_cur.addr[byte_off_lp +: cnt_width_lp];
  // Truncation to cnt_width_lp bits gives the wrap modulo stream_words.
  assign last_cnt    = first_cnt + num_stream[cnt_width_lp-1:0] - cnt_width_lp'(1);

  assign cnt_o      = (state_q == e_ready) ? first_cnt : cnt_q;
  assign fsm_last_o = single_beat | (cnt_o == last_cnt);
  assign fsm_new_o  = single_beat | (state_q == e_ready);

  // Outputs are gated by reset so nothing is offered or consumed while held.
  assign fsm_v_o    = reset_n_i & mem_v_i;
  assign mem_yumi_o = reset_n_i & fsm_yumi_i & (single_beat | has_data | fsm_last_o);
  assign done_o     = reset_n_i & fsm_yumi_i & fsm_last_o;

  // A yumi without a valid beat is not a handshake.
  assign accept = fsm_v_o & fsm_yumi_i;

  assign fsm_base_header_o = hdr_cur;
  assign fsm_data_o        = mem_data_i;
  assign fsm_addr_o        = {hdr_cur.addr[paddr_width_lp-1:blk_off_lp], cnt_o,
                              hdr_cur.addr[byte_off_lp-1:0]};

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    cnt_d    = cnt_q;
    header_d = header_q;
    if (accept && !single_beat) begin
      if (fsm_last_o) begin
        state_d = e_ready;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_o + cnt_width_lp'(1);
        if (state_q == e_ready) begin
          state_d  = has_data ? e_stream : e_expand;
          header_d = mem_header_li;
        end
      end
    end
  end

  // NOTE: the header register is reset too, so fsm_base_header_o never shows X after reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= e_ready;
      cnt_q    <= '0;
      header_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      header_q <= header_d;
    end
  end

`ifdef BP_STREAM_PUMP_IN_PROTOCOL_CHECK_EN
  logic error_q, mismatch;

  // A beat in mid-stream must belong to the same block transfer.
  assign mismatch = (state_q == e_stream) & mem_v_i
                  & ((mem_header_li.msg_type != header_q.msg_type)
                   | (mem_header_li.size     != header_q.size)
                   | (mem_header_li.addr[paddr_width_lp-1:blk_off_lp]
                      != header_q.addr[paddr_width_lp-1:blk_off_lp]));

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      error_q <= 1'b0;
    end else if (mismatch) begin
      error_q <= 1'b1;
    end
  end

  assign error_o = error_q;
`else
  assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_bp_stream_pump_in.sv
module tb_bp_stream_pump_in;
  import bp_stream_pump_in_pkg::*;

  localparam int HW = mem_header_width(e_bp_default_cfg);
  localparam logic [3:0] RD = 4'd0, WR = 4'd1, UC_WR = 4'd3;

  logic          clk, rst_n;
  logic [HW-1:0] mem_header, fsm_hdr;
  logic [63:0]   mem_data, fsm_data;
  logic          mem_v, mem_yumi, fsm_v, fsm_yumi;
  logic [39:0]   fsm_addr;
  logic          fsm_new, fsm_last, done, error;
  logic [2:0]    cnt;

  bp_stream_pump_in #(
    .payload_mask_p(16'b1010)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .mem_header_i(mem_header), .mem_data_i(mem_data), .mem_v_i(mem_v), .mem_yumi_o(mem_yumi),
    .fsm_base_header_o(fsm_hdr), .fsm_addr_o(fsm_addr), .fsm_data_o(fsm_data),
    .fsm_v_o(fsm_v), .fsm_yumi_i(fsm_yumi),
    .fsm_new_o(fsm_new), .fsm_last_o(fsm_last), .cnt_o(cnt), .done_o(done), .error_o(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  cnt;
    logic [39:0] addr;
    logic        new_b;
    logic        last;
    logic        yumi;
    logic        chk_data;
    logic [63:0] data;
  } beat_t;

  beat_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  logic  exp_err;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // {lce_id, way, addr, size, msg_type}
  function automatic logic [HW-1:0] mk_hdr(input logic [3:0] t, input logic [2:0] s,
                                            input logic [39:0] a);
    return {4'h2, 3'h5, a, s, t};
  endfunction

  // Drives one message and checks every FSM beat against the scoreboard.
  // corrupt: from the second bus beat on, the bus header carries a smaller size.
  task automatic run_msg(input logic [3:0] t, input logic [2:0] s, input logic [39:0] a,
                         input bit stall, input bit corrupt);
    int           num, b, cyc;
    bit           hd, fin;
    logic [2:0]   first, c;
    logic [63:0]  bus_data[$];
    logic [63:0]  d0;
    logic [HW-1:0] hdr;
    beat_t        e;
    num = (1 << s) / 8;
    if (num < 1) num = 1;
    if (num > 8) num = 8;
    hd    = (t == WR) || (t == UC_WR);
    first = a[5:3];
    hdr   = mk_hdr(t, s, a);
    d0    = {$urandom, $urandom};
    for (int k = 0; k < num; k++) begin
      logic [63:0] d;
      d = {$urandom, $urandom};
      c = first + 3'(k);
      exp_q.push_back('{c, {a[39:6], c, a[2:0]}, k == 0, k == num - 1,
                        hd || (k == num - 1), hd, d});
      if (hd) bus_data.push_back(d);
    end
    b = 0; cyc = 0; fin = 0;
    while (!fin && cyc < 64) begin
      @(posedge clk); #1;
      mem_v      = 1'b1;
      mem_header = (corrupt && b >= 1) ? mk_hdr(t, s - 3'd1, a) : hdr;
      mem_data   = hd ? bus_data[b] : d0;
      fsm_yumi   = stall ? cyc[0] : 1'b1;
      cyc++;
      @(negedge clk);
      check("fsm_v", fsm_v, 1);
      if (fsm_yumi) begin
        e = exp_q.pop_front();
        check("cnt", cnt, e.cnt);
        check("addr", fsm_addr, e.addr);
        check("new", fsm_new, e.new_b);
        check("last", fsm_last, e.last);
        check("done", done, e.last);
        check("mem_yumi", mem_yumi, e.yumi);
        check("header", fsm_hdr, hdr);
        if (e.chk_data) check("data", fsm_data, e.data);
        if (e.yumi) b++;
        if (e.last) fin = 1;
      end else begin
        check("stall_mem_yumi", mem_yumi, 0);
        check("stall_done", done, 0);
      end
    end
    @(posedge clk); #1;
    mem_v = 1'b0; fsm_yumi = 1'b0;
    if (!fin) begin
      check("timeout", 0, 1);
      exp_q.delete();
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    #3;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
`ifdef BP_STREAM_PUMP_IN_PROTOCOL_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    // Reset: outputs quiet even with valid/yumi driven.
    rst_n      = 1'b0;
    mem_v      = 1'b1;
    fsm_yumi   = 1'b1;
    mem_data   = 64'h0;
    mem_header = mk_hdr(WR, 3'd6, 40'h100);
    #1;
    check("rst_fsm_v", fsm_v, 0);
    check("rst_mem_yumi", mem_yumi, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_cnt", cnt, 0);
    check("rst_new", fsm_new, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mem_v = 1'b0;

    // Yumi without valid is ignored: state stays ready.
    repeat (3) begin
      @(posedge clk); #1;
      fsm_yumi = 1'b1;
    end
    @(negedge clk);
    check("idle_fsm_v", fsm_v, 0);
    check("idle_new", fsm_new, 1);
    @(posedge clk); #1;
    fsm_yumi = 1'b0;

    run_msg(WR,    3'd3, 40'h080, 0, 0);  // single beat write
    run_msg(RD,    3'd3, 40'h098, 0, 0);  // single beat read
    run_msg(WR,    3'd6, 40'h100, 1, 0);  // full block, stalled
    run_msg(WR,    3'd6, 40'h128, 0, 0);  // wrapping block
    run_msg(RD,    3'd6, 40'h200, 1, 0);  // expand, stalled
    run_msg(UC_WR, 3'd5, 40'h130, 0, 0);  // 4 beats with wrap
    @(negedge clk);
    check("no_error", error, 0);

    // Reset after the third beat of a 64B stream.
    mem_header = mk_hdr(WR, 3'd6, 40'h100);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      mem_v = 1'b1; fsm_yumi = 1'b1; mem_data = 64'(i);
      @(negedge clk);
      check("pre_rst_cnt", cnt, 3'(i));
    end
    @(posedge clk); #1;
    fsm_yumi = 1'b0;
    @(negedge clk);
    check("mid_stream_new", fsm_new, 0);
    check("mid_stream_cnt", cnt, 3);
    #1;
    rst_n = 1'b0;
    mem_header = mk_hdr(RD, 3'd6, 40'h200);
    #1;
    check("mid_rst_new", fsm_new, 1);
    check("mid_rst_hdr", fsm_hdr, mk_hdr(RD, 3'd6, 40'h200));
    check("mid_rst_cnt", cnt, 0);
    check("mid_rst_fsm_v", fsm_v, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_v = 1'b0;
    run_msg(WR, 3'd6, 40'h140, 0, 0);

    // Header size changes on the second beat.
    run_msg(WR, 3'd6, 40'h180, 0, 1);
    @(negedge clk);
    check("proto_error", error, exp_err);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("proto_error_sticky", error, exp_err);
    pulse_reset();
    #1;
    check("error_cleared", error, 0);
    check("queue_empty", 64'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_stream_pump_in.md
BP_STREAM_PUMP_IN -- requirements
Module: bp_stream_pump_in

Interface
REQ-001 SHALL have parameter: bp_params_p, e_bp_default_cfg, processor configuration supplying paddr_width_p, lce_id_width_p, lce_assoc_p, dword_width_p, cce_block_width_p.
REQ-002 SHALL have parameter: stream_data_width_p, dword_width_p, bits per bus beat.
REQ-003 SHALL have parameter: block_width_p, cce_block_width_p, maximum message payload in bits; stream_words = block_width_p/stream_data_width_p.
REQ-004 SHALL have parameter: payload_mask_p, 0, bitmask of msg_type values that carry a data payload.
REQ-005 SHALL have port: clk_i  in  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port: reset_n_i  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports: mem_header_i  in  xce mem header width  incoming bedrock header; mem_data_i  in  stream_data_width_p  beat data; mem_v_i  in  1  beat valid; mem_yumi_o  out  1  beat consumed.
REQ-008 SHALL have ports: fsm_base_header_o  out  header width  message header; fsm_addr_o  out  paddr_width_p  per-beat address; fsm_data_o  out  stream_data_width_p; fsm_v_o  out  1; fsm_yumi_i  in  1.
REQ-009 SHALL have ports: fsm_new_o  out  1  first beat of message; fsm_last_o  out  1  last beat; cnt_o  out  clog2(stream_words)  beat index; done_o  out  1  message complete; error_o  out  1  sticky protocol error.

Function
REQ-010 num_stream SHALL equal max((1<<size)/(stream_data_width_p/8), 1), computed at data_len width+1 (no overflow at stream_words).
REQ-011 first_cnt SHALL be addr[offset+:len] of the message header; last_cnt = (first_cnt + num_stream - 1) mod stream_words.
REQ-012 States SHALL be e_ready, e_stream, e_expand; reset state e_ready.
REQ-013 Single-beat (num_stream==1) in any state: fsm_v_o=mem_v_i, mem_yumi_o=fsm_yumi_i, fsm_new_o=fsm_last_o=1, done_o=fsm_yumi_i, fsm_addr_o=header addr; state unchanged.
REQ-014 Data stream (has_data, num_stream>1): each bus beat maps 1:1 to an FSM beat; mem_yumi_o=fsm_yumi_i; fsm_data_o=mem_data_i, zero added latency.
REQ-015 On first accepted data beat in e_ready, header SHALL be registered and state SHALL go to e_stream; fsm_base_header_o SHALL then present the registered header until done.
REQ-016 Expand (no data, num_stream>1): one bus message SHALL yield num_stream FSM beats; fsm_v_o=mem_v_i; mem_yumi_o=fsm_yumi_i & fsm_last_o; state e_expand after first accepted beat.
REQ-017 cnt_o SHALL be first_cnt in e_ready, else the counter register; counter increments per fsm_yumi_i, wrapping stream_words-1 -> 0.
REQ-018 fsm_addr_o SHALL be {header addr upper bits, cnt_o, header addr byte-offset bits}.
REQ-019 fsm_new_o SHALL be 1 only in e_ready; fsm_last_o SHALL be (cnt_o==last_cnt).
REQ-020 done_o SHALL equal fsm_last_o & fsm_yumi_i; on done, state SHALL return to e_ready same edge, counter reloads.
REQ-021 fsm_yumi_i without fsm_v_o SHALL be ignored; no FSM beat emitted without mem_v_i.
REQ-022 Combinational path mem_v_i->fsm_v_o and fsm_yumi_i->mem_yumi_o SHALL exist; no path mem_v_i->mem_yumi_o.

Reset
REQ-023 Asserting reset_n_i low SHALL immediately force e_ready, counter 0, header register 0, error_o 0, including mid-stream.
REQ-024 During reset mem_yumi_o, fsm_v_o, done_o SHALL be 0; first beat accepted at earliest on the first edge after deassertion.

Configuration
REQ-025 Macro BP_STREAM_PUMP_IN_PROTOCOL_CHECK_EN defined: in e_stream, a valid beat whose msg_type, size, or addr above block offset differs from the registered header SHALL set error_o, sticky until reset; beat still forwarded.
REQ-026 Macro undefined: error_o SHALL be constant 0 and no comparison logic instantiated.

Verification
REQ-027 Single beat: 8B write, size=8B, addr 0x80 -> one FSM beat, new=last=1, cnt_o=0, done_o with fsm_yumi_i.
REQ-028 64B write, 8 stream words, addr 0x100, fsm_yumi_i stalled alternate cycles -> 8 FSM beats cnt 0..7, addrs 0x100..0x138, done on 8th.
REQ-029 Wrap: 64B write, addr 0x128 -> cnt 5,6,7,0,1,2,3,4; last_o on cnt 4.
REQ-030 Expand: 64B read no data, addr 0x200 -> 8 FSM beats, mem_yumi_o high only with 8th fsm_yumi_i.
REQ-031 Reset asserted after 3rd beat of 64B stream -> state e_ready, cnt_o 0; next message starts fresh with fsm_new_o=1.
REQ-032 With PROTOCOL_CHECK_EN: change size on 2nd beat -> error_o=1 next cycle, held until reset; undefined -> error_o stays 0.
